// File: rtl/mic_capture_ctrl.sv
// mic_capture_ctrl
// Session controller for an I2S microphone receiver. While idle, the block
// holds the receiver in reset. A start command releases the receiver. The
// first DISCARD_COUNT strobes are dropped as warm-up. The block then captures
// sample_count samples (0 = until stop) into a small FIFO. The FIFO feeds a
// valid/ready stream to the downstream consumer.
//
// Ports:
//   clk, rst_n             system clock, asynchronous active-low reset
//   start, stop            one-cycle commands (start ignored while busy)
//   sample_count           samples to capture, latched on accepted start
//   rx_rst_n               active-low reset to the receiver
//   rx_data, rx_valid      sample stream from the receiver
//   m_data, m_valid, m_ready  downstream stream (FIFO head)
//   busy, done             session active / one-cycle end-of-session pulse
//   overflow               sticky: a sample was dropped on a full FIFO
//   captured               samples written to the FIFO this session
module mic_capture_ctrl #(
  parameter int DATA_SIZE     = 16,
  parameter int CNT_W         = 16,
  parameter int DISCARD_COUNT = 64,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [CNT_W-1:0]     sample_count,
  output logic                 rx_rst_n,
  input  logic [DATA_SIZE-1:0] rx_data,
  input  logic                 rx_valid,
  output logic [DATA_SIZE-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [CNT_W-1:0]     captured
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DISC = CNT_W'(DISCARD_COUNT);

  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_CAPTURE, S_DRAIN} state_t;

  state_t                 r_state, w_next;
  logic [CNT_W-1:0]       r_latch, r_disc, r_sess, r_captured;
  logic                   r_overflow, r_done;
  logic                   w_done_set, w_rx_en;
  logic [DATA_SIZE-1:0]   r_mem [FIFO_DEPTH];
  logic [AW:0]            r_wp, r_rp;

  logic                   w_empty, w_full, w_pop, w_ev, w_push, w_drop, w_start;
  logic [CNT_W-1:0]       w_sess_nx, w_disc_nx;

  // The pointers carry one extra wrap bit so that the FIFO can tell full
  // from empty.
  assign w_empty   = (r_wp == r_rp);
  assign w_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_pop     = !w_empty && m_ready;
  assign w_ev      = (r_state == S_CAPTURE) && rx_valid;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_push    = w_ev && (!w_full || w_pop);
  assign w_drop    = w_ev && !w_push;
  assign w_start   = (r_state == S_IDLE) && start;
  assign w_disc_nx = r_disc + 1'b1;
  // The session counter saturates. This stops continuous mode from wrapping
  // onto a programmed count.
  assign w_sess_nx = (r_sess == '1) ? r_sess : r_sess + 1'b1;

  always_comb begin
    w_next     = r_state;
    w_done_set = 1'b0;
    w_rx_en    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = (DISCARD_COUNT == 0) ? S_CAPTURE : S_WARMUP;
      end
      S_WARMUP: begin
        w_rx_en = 1'b1;
        if (stop) begin
          w_next     = S_IDLE;
          w_done_set = 1'b1;
        end else if (rx_valid && w_disc_nx == DISC) begin
          w_next = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        w_rx_en = 1'b1;
        if (stop || (w_ev && r_latch != '0 && w_sess_nx == r_latch))
          w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_empty) begin
          w_next     = S_IDLE;
          w_done_set = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_done     <= 1'b0;
      r_latch    <= '0;
      r_disc     <= '0;
      r_sess     <= '0;
      r_captured <= '0;
      r_overflow <= 1'b0;
      r_wp       <= '0;
      r_rp       <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= w_done_set;
      if (w_start) begin
        r_latch    <= sample_count;
        r_disc     <= '0;
        r_sess     <= '0;
        r_captured <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (r_state == S_WARMUP && rx_valid) r_disc <= w_disc_nx;
        if (w_ev) r_sess <= w_sess_nx;
        if (w_push && r_captured != '1) r_captured <= r_captured + 1'b1;
        if (w_drop) r_overflow <= 1'b1;
      end
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  // The storage needs no reset. The pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= rx_data;
  end

  assign m_valid  = !w_empty;
  assign m_data   = w_empty ? '0 : r_mem[r_rp[AW-1:0]];
  assign rx_rst_n = w_rx_en;
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign overflow = r_overflow;
  assign captured = r_captured;

endmodule

// File: tb/tb_mic_capture_ctrl.sv
module tb_mic_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, rx_valid, m_ready;
  logic [15:0] sample_count, rx_data;
  logic        rx_rst_n, m_valid, busy, done, overflow;
  logic [15:0] m_data, captured;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] sb_q[$];

  mic_capture_ctrl #(.DATA_SIZE(16), .CNT_W(16), .DISCARD_COUNT(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .sample_count(sample_count), .rx_rst_n(rx_rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .done(done), .overflow(overflow), .captured(captured)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Status word: {busy, rx_rst_n, done, m_valid, overflow, captured}.
  task automatic chk_st(input string nm, input logic b, input logic r, input logic d,
                        input logic v, input logic o, input logic [15:0] c);
    chk(nm, {busy, rx_rst_n, done, m_valid, overflow, captured}, {b, r, d, v, o, c});
  endtask

  // Advance one clock. A pop is scored at the negedge in front of the edge
  // that performs it. The one-cycle command pulses drop afterwards.
  task automatic tick();
    logic [15:0] e;
    @(negedge clk);
    if (m_valid && m_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_pop", {48'd0, m_data}, 64'hDEAD);
      end else begin
        e = sb_q.pop_front();
        chk("sb_data", {48'd0, m_data}, {48'd0, e});
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0; rx_valid = 1'b0; rx_data = '0;
  endtask

  task automatic strobe(input logic [15:0] d, input bit push);
    rx_valid = 1'b1;
    rx_data  = d;
    if (push) sb_q.push_back(d);
    tick();
  endtask

  task automatic warmup();
    for (int i = 0; i < 4; i++) strobe(16'h0A00 + 16'(i), 1'b0);
  endtask

  task automatic wait_done(input string nm);
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk(nm, {63'd0, seen}, 64'd1);
    chk(nm, {62'd0, busy, rx_rst_n}, 64'd0);
    tick();
    chk({nm, "_pulse"}, {63'd0, done}, 64'd0);
    chk({nm, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
  endtask

  typedef struct {
    logic st; logic [15:0] cnt; logic rv; logic [15:0] rd; logic wr;
    logic b; logic r; logic d; logic v; logic [15:0] c;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1'b1, 16'd3, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[1]  = '{1'b0, 16'd0, 1'b1, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[2]  = '{1'b0, 16'd0, 1'b1, 16'h0002, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[3]  = '{1'b0, 16'd0, 1'b1, 16'h0003, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[4]  = '{1'b0, 16'd0, 1'b1, 16'h0004, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[5]  = '{1'b0, 16'd0, 1'b1, 16'h0005, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'd1};
    tbl[6]  = '{1'b0, 16'd0, 1'b1, 16'h0006, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'd2};
    tbl[7]  = '{1'b0, 16'd0, 1'b1, 16'h0007, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd3};
    tbl[8]  = '{1'b0, 16'd0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3};
    tbl[9]  = '{1'b0, 16'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd3};
    tbl[10] = '{1'b0, 16'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3};

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; rx_valid = 1'b0;
    rx_data = '0; sample_count = '0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_st("reset_state", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    chk("reset_mdata", {48'd0, m_data}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic session: 4 warm-up drops, 3 captures, drain, done.
    m_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      start = tbl[i].st; sample_count = tbl[i].cnt;
      rx_valid = tbl[i].rv; rx_data = tbl[i].rd;
      if (tbl[i].wr) sb_q.push_back(tbl[i].rd);
      tick();
      chk_st($sformatf("basic_v%0d", i), tbl[i].b, tbl[i].r, tbl[i].d, tbl[i].v, 1'b0, tbl[i].c);
    end
    chk("basic_sb_empty", 64'(sb_q.size()), 64'd0);

    // Overflow: 8 events with a stalled consumer, 4 kept and 4 dropped.
    m_ready = 1'b0;
    start = 1'b1; sample_count = 16'd8; tick();
    warmup();
    for (int i = 0; i < 8; i++) strobe(16'h0020 + 16'(i), i < 4);
    chk_st("ovf_state", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd4);
    chk("ovf_head", {48'd0, m_data}, 64'h20);
    tick();
    chk("ovf_head_held", {48'd0, m_data}, 64'h20);
    m_ready = 1'b1;
    wait_done("ovf_done");

    // A new start clears overflow. A full FIFO with a same-cycle pop does not drop.
    m_ready = 1'b0;
    start = 1'b1; sample_count = 16'd6; tick();
    chk_st("restart_clear", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    warmup();
    for (int i = 0; i < 4; i++) strobe(16'h0030 + 16'(i), 1'b1);
    chk_st("full_state", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd4);
    m_ready = 1'b1;
    strobe(16'h0034, 1'b1);
    m_ready = 1'b0;
    chk_st("full_pushpop", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd5);
    strobe(16'h0035, 1'b0);
    chk_st("full_still4", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd5);
    m_ready = 1'b1;
    wait_done("full_done");

    // Stop during warm-up: immediate idle with done and an empty FIFO.
    start = 1'b1; sample_count = 16'd5; tick();
    strobe(16'h0B00, 1'b0);
    strobe(16'h0B01, 1'b0);
    stop = 1'b1; tick();
    chk_st("warm_stop", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    tick();
    chk("warm_stop_pulse", {63'd0, done}, 64'd0);

    // Continuous mode: the 10th strobe coincides with stop and still counts.
    start = 1'b1; sample_count = 16'd0; tick();
    warmup();
    for (int i = 0; i < 9; i++) strobe(16'h0040 + 16'(i), 1'b1);
    stop = 1'b1;
    strobe(16'h0049, 1'b1);
    chk_st("cont_stop", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd10);
    wait_done("cont_done");

    // Start+stop together in IDLE: start wins. A start while busy is ignored.
    start = 1'b1; stop = 1'b1; sample_count = 16'd2; tick();
    chk("startstop_busy", {63'd0, busy}, 64'd1);
    start = 1'b1; sample_count = 16'd5; tick();
    warmup();
    strobe(16'h0060, 1'b1);
    strobe(16'h0061, 1'b1);
    chk("busy_start_ignored", {62'd0, rx_rst_n, busy}, 64'd1);
    chk("busy_start_capt", {48'd0, captured}, 64'd2);
    wait_done("busy_done");

    // Asynchronous reset in the middle of a capture.
    m_ready = 1'b0;
    start = 1'b1; sample_count = 16'd0; tick();
    warmup();
    strobe(16'h0070, 1'b0);
    strobe(16'h0071, 1'b0);
    chk("pre_rst_valid", {63'd0, m_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk_st("midrst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_st($sformatf("post_rst_%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mic_capture_ctrl.md
Name: mic_capture_ctrl

Overview:
Session controller for the I2S microphone receiver.
- Holds the receiver in reset while idle, releases it on a capture command and discards a fixed number of warm-up samples.
- Then captures a programmed number of samples into a small FIFO and hands them downstream over a valid/ready stream.
- Sits between the receiver output and the sample consumer (SPI/UART bridge or buffer memory).

Parameters:
DATA_SIZE, 16, width of one audio sample
CNT_W, 16, width of sample counters
DISCARD_COUNT, 64, warm-up samples dropped after receiver release (0 = none)
FIFO_DEPTH, 4, output FIFO entries (power of two, >=2)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
start  input  1  one-cycle capture command; ignored while busy=1
stop  input  1  one-cycle abort/stop command
sample_count  input  CNT_W  samples to capture; sampled on accepted start; 0 = continuous until stop
rx_rst_n  output  1  active-low reset driven to the receiver
rx_data  input  DATA_SIZE  sample from receiver
rx_valid  input  1  one-cycle strobe, rx_data valid
m_data  output  DATA_SIZE  FIFO head sample
m_valid  output  1  FIFO non-empty
m_ready  input  1  consumer accepts m_data when m_valid=1
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse on session end
overflow  output  1  sticky: a sample was dropped on full FIFO; cleared on accepted start
captured  output  CNT_W  samples written to FIFO in current/last session

Behaviour:
- Reset (async, rst_n=0): state IDLE, FIFO flushed.
  - Outputs: rx_rst_n=0, m_valid=0, m_data=0, busy=0, done=0, overflow=0, captured=0.
- States: IDLE, WARMUP, CAPTURE, DRAIN.
- IDLE: rx_rst_n=0.
  - start=1 latches sample_count, clears overflow/captured and the discard counter.
  - Next state: WARMUP, or CAPTURE if DISCARD_COUNT=0.
- WARMUP: rx_rst_n=1. Each rx_valid increments the discard counter; the sample is not written.
  - When the counter reaches DISCARD_COUNT, go to CAPTURE on the cycle after the last discarded strobe.
  - stop=1: go to IDLE, done pulses, FIFO untouched (empty).
- CAPTURE: rx_rst_n=1. Each rx_valid is a sample event.
  - FIFO not full, or full with a same-cycle pop: write, captured+1.
  - Otherwise: drop, overflow=1.
  - Every event (written or dropped) increments the session counter.
  - Session counter == latched count (non-zero): go to DRAIN.
  - stop=1: go to DRAIN. A rx_valid in the same cycle as stop is still processed.
- DRAIN: rx_rst_n=0; rx_valid ignored. Once the FIFO is empty, done pulses for one cycle and the state returns to IDLE.
- FIFO: write on a rx_valid cycle makes m_valid=1 on the next cycle (1-cycle latency).
  - Pop when m_valid & m_ready; m_data is held stable while m_valid=1 and m_ready=0.
  - Push and pop in the same cycle are legal at any occupancy.
- Counters wrap never: sample_count is at most 2^CNT_W-1; in continuous mode captured saturates at all-ones.
- start while busy: ignored, no state change. start and stop in the same cycle in IDLE: start wins, stop ignored.
- Async reset mid-session: immediate return to IDLE, FIFO contents lost, no done pulse.

Test Plan:
- DISCARD_COUNT=4, sample_count=3, m_ready=1, rx_valid with data 0x0001..0x0007 -> rx_rst_n rises the cycle after start; first 4 samples dropped; m_data 0x0005,0x0006,0x0007; captured=3; done pulses once after last pop; rx_rst_n=0.
- sample_count=8, m_ready=0, FIFO_DEPTH=4 -> 4 samples held, 4 dropped, overflow=1, captured=4; raising m_ready drains 4 in order, then done; next start clears overflow.
- FIFO full with m_ready=1 and rx_valid in the same cycle -> no drop, overflow stays 0, occupancy stays 4.
- sample_count=0, 10 strobes then stop -> captured=10, DRAIN, done after FIFO empty; stop during WARMUP -> immediate IDLE with done, no m_valid.
- start pulsed while busy -> latched count unchanged; rst_n asserted mid-CAPTURE -> m_valid=0, busy=0, rx_rst_n=0 immediately, no done.
